// File: rtl/bru_pipe.sv
// Registered RV32I branch resolution: target, link, direction and mispredict, one cycle after accept; holds while !out_rdy.
// Trains a 2-bit BHT on retirement. Define BRU_MISALIGN_EXC_EN to raise out_exc on misaligned taken targets.
module bru_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int BHT_IDX_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [1:0]            in_type,
  input  logic [2:0]            in_funct3,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_pred_taken,
  input  logic [PC_WIDTH-1:0]   in_pred_pc,
  input  logic                  kill,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_flush,
  output logic [PC_WIDTH-1:0]   out_redir_pc,
  output logic                  out_taken,
  output logic [DATA_WIDTH-1:0] out_link,
  output logic                  out_exc,
  input  logic [PC_WIDTH-1:0]   bht_rd_pc,
  output logic                  bht_rd_taken
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  logic                  w_eq, w_lt, w_ltu, w_cond, w_taken;
  logic                  w_mispred, w_flush, w_exc, w_acc, w_bht_we;
  logic [DATA_WIDTH-1:0] w_jalr_sum;
  logic [PC_WIDTH-1:0]   w_br_tgt, w_jalr_tgt, w_target, w_pc4, w_redir;
  logic [BHT_IDX_W-1:0]  w_rd_idx;
  logic                  w_unused_pc;

  logic                  r_vld, r_flush, r_taken, r_exc, r_is_br;
  logic [PC_WIDTH-1:0]   r_redir;
  logic [DATA_WIDTH-1:0] r_link;
  logic [BHT_IDX_W-1:0]  r_idx;
  logic [1:0]            r_bht [BHT_N];

  assign w_eq  = (in_rs1 == in_rs2);
  assign w_lt  = ($signed(in_rs1) < $signed(in_rs2));
  assign w_ltu = (in_rs1 < in_rs2);

  always_comb begin
    w_cond = 1'b0;
    case (in_funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = !w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (in_type)
      2'b00:   w_taken = w_cond;
      2'b01,
      2'b10:   w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_br_tgt   = in_pc + PC_WIDTH'(in_imm);
  assign w_jalr_sum = in_rs1 + in_imm;
  assign w_jalr_tgt = PC_WIDTH'(w_jalr_sum) & ~PC_WIDTH'(1);
  assign w_target   = (in_type == 2'b10) ? w_jalr_tgt : w_br_tgt;
  assign w_pc4      = in_pc + PC_WIDTH'(4);
  assign w_redir    = w_taken ? w_target : w_pc4;
  assign w_mispred  = (w_taken != in_pred_taken) | (w_taken & (w_target != in_pred_pc));

`ifdef BRU_MISALIGN_EXC_EN
  // The trap handler takes over, so a misaligned result never redirects or trains.
  assign w_exc   = w_taken & w_target[1];
  assign w_flush = w_mispred & !w_exc;
`else
  assign w_exc   = 1'b0;
  assign w_flush = w_mispred;
`endif

  assign in_rdy   = !r_vld | out_rdy;
  assign w_acc    = in_vld & in_rdy & !kill;
  assign w_bht_we = r_vld & out_rdy & !kill & r_is_br;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_flush <= 1'b0;
      r_taken <= 1'b0;
      r_exc   <= 1'b0;
      r_is_br <= 1'b0;
      r_redir <= '0;
      r_link  <= '0;
      r_idx   <= '0;
    end else if (kill) begin
      r_vld <= 1'b0;
    end else if (w_acc) begin
      r_vld   <= 1'b1;
      r_flush <= w_flush;
      r_taken <= w_taken;
      r_exc   <= w_exc;
      r_is_br <= (in_type == 2'b00) & !w_exc;
      r_redir <= w_redir;
      r_link  <= DATA_WIDTH'(w_pc4);
      r_idx   <= in_pc[BHT_IDX_W+1:2];
    end else if (out_rdy) begin
      r_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
    end else if (w_bht_we) begin
      if (r_taken && r_bht[r_idx] != 2'b11)
        r_bht[r_idx] <= r_bht[r_idx] + 2'b01;
      else if (!r_taken && r_bht[r_idx] != 2'b00)
        r_bht[r_idx] <= r_bht[r_idx] - 2'b01;
    end
  end

  // Reads see the registered array, so a same-cycle write is not forwarded.
  assign w_rd_idx     = bht_rd_pc[BHT_IDX_W+1:2];
  assign bht_rd_taken = r_bht[w_rd_idx][1];
  assign w_unused_pc  = ^{bht_rd_pc[PC_WIDTH-1:BHT_IDX_W+2], bht_rd_pc[1:0]};

  assign out_vld      = r_vld;
  assign out_flush    = r_flush;
  assign out_taken    = r_taken;
  assign out_exc      = r_exc;
  assign out_redir_pc = r_redir;
  assign out_link     = r_link;

endmodule

// File: tb/tb_bru_pipe.sv
// Directed bench for bru_pipe: per-scenario tasks with hand-computed expectations.
module tb_bru_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld, in_rdy;
  logic [1:0]  in_type;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm, in_pred_pc;
  logic        in_pred_taken, kill;
  logic        out_vld, out_rdy, out_flush, out_taken, out_exc;
  logic [31:0] out_redir_pc, out_link;
  logic [31:0] bht_rd_pc;
  logic        bht_rd_taken;
  int          n_run = 0;
  int          n_fail = 0;
  logic        exp_exc_jalr;

  bru_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_type(in_type),
    .in_funct3(in_funct3), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .in_pred_pc(in_pred_pc), .kill(kill), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_flush(out_flush), .out_redir_pc(out_redir_pc), .out_taken(out_taken),
    .out_link(out_link), .out_exc(out_exc), .bht_rd_pc(bht_rd_pc), .bht_rd_taken(bht_rd_taken)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ppc);
    in_type = t; in_funct3 = f3; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_pred_taken = pt; in_pred_pc = ppc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; kill = 1'b0; bht_rd_pc = 32'h0;
    set_in(2'b11, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #12;
    n_run++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld got=%b exp=0", out_vld); end
    n_run++; if ({out_flush, out_taken, out_exc} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got=%b exp=000", {out_flush, out_taken, out_exc}); end
    n_run++; if (out_redir_pc !== 32'h0 || out_link !== 32'h0) begin n_fail++; $display("FAIL rst_data got=%h/%h exp=0/0", out_redir_pc, out_link); end
    n_run++; if (bht_rd_taken !== 1'b0) begin n_fail++; $display("FAIL rst_bht got=%b exp=0", bht_rd_taken); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_run++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_in_rdy got=%b exp=1", in_rdy); end
  endtask

  task automatic test_beq();
    set_in(2'b00, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
    bht_rd_pc = 32'h100; in_vld = 1'b1;
    tick(); in_vld = 1'b0;
    n_run++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL beq_vld got=%b exp=1", out_vld); end
    n_run++; if (out_taken !== 1'b1 || out_flush !== 1'b1) begin n_fail++; $display("FAIL beq_tk_fl got=%b%b exp=11", out_taken, out_flush); end
    n_run++; if (out_redir_pc !== 32'h120) begin n_fail++; $display("FAIL beq_redir got=%h exp=120", out_redir_pc); end
    n_run++; if (out_link !== 32'h104) begin n_fail++; $display("FAIL beq_link got=%h exp=104", out_link); end
    n_run++; if (bht_rd_taken !== 1'b0) begin n_fail++; $display("FAIL beq_bht_collide got=%b exp=0", bht_rd_taken); end
    tick();
    n_run++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL beq_retire got=%b exp=0", out_vld); end
    n_run++; if (bht_rd_taken !== 1'b1) begin n_fail++; $display("FAIL beq_bht got=%b exp=1", bht_rd_taken); end
  endtask

  task automatic test_bltu_blt();
    set_in(2'b00, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0, 32'h0);
    in_vld = 1'b1;
    tick();
    n_run++; if (out_taken !== 1'b0 || out_flush !== 1'b0) begin n_fail++; $display("FAIL bltu_tk_fl got=%b%b exp=00", out_taken, out_flush); end
    n_run++; if (out_redir_pc !== 32'h204) begin n_fail++; $display("FAIL bltu_redir got=%h exp=204", out_redir_pc); end
    set_in(2'b00, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0, 32'h0);
    tick(); in_vld = 1'b0;
    n_run++; if (out_vld !== 1'b1 || out_taken !== 1'b1 || out_flush !== 1'b1) begin n_fail++; $display("FAIL blt_vtf got=%b%b%b exp=111", out_vld, out_taken, out_flush); end
    n_run++; if (out_redir_pc !== 32'h240) begin n_fail++; $display("FAIL blt_redir got=%h exp=240", out_redir_pc); end
    tick();
    bht_rd_pc = 32'h200;
    #1;
    n_run++; if (bht_rd_taken !== 1'b1) begin n_fail++; $display("FAIL blt_bht got=%b exp=1", bht_rd_taken); end
  endtask

  task automatic test_jumps();
    set_in(2'b10, 3'b000, 32'h300, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h1002);
    in_vld = 1'b1; tick(); in_vld = 1'b0;
    n_run++; if (out_redir_pc !== 32'h1002 || out_link !== 32'h304) begin n_fail++; $display("FAIL jalr_pc got=%h/%h exp=1002/304", out_redir_pc, out_link); end
    n_run++; if (out_flush !== 1'b0 || out_taken !== 1'b1) begin n_fail++; $display("FAIL jalr_fl_tk got=%b%b exp=01", out_flush, out_taken); end
    n_run++; if (out_exc !== exp_exc_jalr) begin n_fail++; $display("FAIL jalr_exc got=%b exp=%b", out_exc, exp_exc_jalr); end
    tick();
    set_in(2'b01, 3'b000, 32'h400, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b1, 32'h3FC);
    in_vld = 1'b1; tick(); in_vld = 1'b0;
    n_run++; if (out_redir_pc !== 32'h3F8 || out_flush !== 1'b1 || out_exc !== 1'b0) begin n_fail++; $display("FAIL jal_wrongpc got=%h/%b/%b exp=3f8/1/0", out_redir_pc, out_flush, out_exc); end
    tick();
    set_in(2'b11, 3'b000, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    in_vld = 1'b1; tick(); in_vld = 1'b0;
    n_run++; if (out_redir_pc !== 32'h0 || out_link !== 32'h0) begin n_fail++; $display("FAIL none_wrap got=%h/%h exp=0/0", out_redir_pc, out_link); end
    n_run++; if (out_taken !== 1'b0 || out_flush !== 1'b0) begin n_fail++; $display("FAIL none_tk_fl got=%b%b exp=00", out_taken, out_flush); end
    tick();
    set_in(2'b00, 3'b010, 32'h10, 32'd7, 32'd7, 32'h40, 1'b0, 32'h0);
    in_vld = 1'b1; tick(); in_vld = 1'b0;
    n_run++; if (out_taken !== 1'b0 || out_redir_pc !== 32'h14) begin n_fail++; $display("FAIL f3_010 got=%b/%h exp=0/14", out_taken, out_redir_pc); end
    tick();
    set_in(2'b01, 3'b000, 32'h700, 32'h0, 32'h0, 32'h2, 1'b0, 32'h0);
    in_vld = 1'b1; tick(); in_vld = 1'b0;
    n_run++; if (out_redir_pc !== 32'h702) begin n_fail++; $display("FAIL mis_redir got=%h exp=702", out_redir_pc); end
    n_run++; if ({out_exc, out_flush} !== (exp_exc_jalr ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL mis_exc_fl got=%b%b exp=%b%b", out_exc, out_flush, exp_exc_jalr, !exp_exc_jalr); end
    tick();
  endtask

  task automatic test_backpressure();
    bht_rd_pc = 32'h80; out_rdy = 1'b0;
    set_in(2'b00, 3'b001, 32'h80, 32'd1, 32'd2, 32'h10, 1'b1, 32'h90);
    in_vld = 1'b1; tick();
    set_in(2'b00, 3'b111, 32'h84, 32'd1, 32'd2, 32'h10, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      n_run++; if (in_rdy !== 1'b0 || out_vld !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d rdy/vld got=%b%b exp=01", c, in_rdy, out_vld); end
      n_run++; if (out_redir_pc !== 32'h90 || out_taken !== 1'b1 || out_flush !== 1'b0) begin n_fail++; $display("FAIL bp_stable%0d got=%h/%b/%b exp=90/1/0", c, out_redir_pc, out_taken, out_flush); end
      n_run++; if (bht_rd_taken !== 1'b0) begin n_fail++; $display("FAIL bp_bht%0d got=%b exp=0", c, bht_rd_taken); end
      tick();
    end
    out_rdy = 1'b1; #1;
    n_run++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b exp=1", in_rdy); end
    tick(); in_vld = 1'b0;
    n_run++; if (out_vld !== 1'b1 || out_redir_pc !== 32'h88 || out_taken !== 1'b0) begin n_fail++; $display("FAIL bp_second got=%b/%h/%b exp=1/88/0", out_vld, out_redir_pc, out_taken); end
    n_run++; if (bht_rd_taken !== 1'b1) begin n_fail++; $display("FAIL bp_bht_a got=%b exp=1", bht_rd_taken); end
    tick();
    n_run++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", out_vld); end
  endtask

  task automatic test_saturation();
    bht_rd_pc = 32'h40;
    for (int k = 0; k < 4; k++) begin
      set_in(2'b00, 3'b000, 32'h40, 32'd3, 32'd3, 32'h8, 1'b1, 32'h48);
      in_vld = 1'b1; tick(); in_vld = 1'b0; tick();
    end
    n_run++; if (bht_rd_taken !== 1'b1) begin n_fail++; $display("FAIL sat_hi got=%b exp=1", bht_rd_taken); end
    for (int k = 0; k < 4; k++) begin
      set_in(2'b00, 3'b001, 32'h40, 32'd3, 32'd3, 32'h8, 1'b0, 32'h0);
      in_vld = 1'b1; tick(); in_vld = 1'b0; tick();
      if (k == 0) begin
        n_run++; if (bht_rd_taken !== 1'b1) begin n_fail++; $display("FAIL sat_11_to_10 got=%b exp=1", bht_rd_taken); end
      end
      if (k == 1) begin
        n_run++; if (bht_rd_taken !== 1'b0) begin n_fail++; $display("FAIL sat_to_01 got=%b exp=0", bht_rd_taken); end
      end
    end
    set_in(2'b00, 3'b000, 32'h40, 32'd3, 32'd3, 32'h8, 1'b1, 32'h48);
    in_vld = 1'b1; tick(); in_vld = 1'b0; tick();
    n_run++; if (bht_rd_taken !== 1'b0) begin n_fail++; $display("FAIL sat_lo got=%b exp=0", bht_rd_taken); end
  endtask

  task automatic test_kill();
    bht_rd_pc = 32'h500;
    set_in(2'b00, 3'b001, 32'h500, 32'd4, 32'd4, 32'h8, 1'b0, 32'h0);
    in_vld = 1'b1; tick();
    n_run++; if (out_vld !== 1'b1 || bht_rd_taken !== 1'b1) begin n_fail++; $display("FAIL kill_pre got=%b/%b exp=1/1", out_vld, bht_rd_taken); end
    set_in(2'b01, 3'b000, 32'h600, 32'h0, 32'h0, 32'h10, 1'b0, 32'h0);
    kill = 1'b1; tick(); kill = 1'b0; in_vld = 1'b0;
    n_run++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL kill_vld got=%b exp=0", out_vld); end
    n_run++; if (bht_rd_taken !== 1'b1) begin n_fail++; $display("FAIL kill_bht got=%b exp=1", bht_rd_taken); end
    tick();
    n_run++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL kill_drop got=%b exp=0", out_vld); end
  endtask

  task automatic test_mid_reset();
    bht_rd_pc = 32'h100;
    set_in(2'b00, 3'b000, 32'h100, 32'd1, 32'd1, 32'h4, 1'b1, 32'h104);
    in_vld = 1'b1; out_rdy = 1'b0; tick(); in_vld = 1'b0;
    n_run++; if (out_vld !== 1'b1 || bht_rd_taken !== 1'b1) begin n_fail++; $display("FAIL mrst_pre got=%b/%b exp=1/1", out_vld, bht_rd_taken); end
    #2 rst_n = 1'b0; #1;
    n_run++; if (out_vld !== 1'b0 || out_redir_pc !== 32'h0) begin n_fail++; $display("FAIL mrst_out got=%b/%h exp=0/0", out_vld, out_redir_pc); end
    n_run++; if (bht_rd_taken !== 1'b0) begin n_fail++; $display("FAIL mrst_bht got=%b exp=0", bht_rd_taken); end
    @(negedge clk); rst_n = 1'b1; out_rdy = 1'b1;
    tick();
  endtask

  initial begin
`ifdef BRU_MISALIGN_EXC_EN
    exp_exc_jalr = 1'b1;
`else
    exp_exc_jalr = 1'b0;
`endif
    test_reset();
    test_beq();
    test_bltu_blt();
    test_jumps();
    test_backpressure();
    test_saturation();
    test_kill();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
